// File: rtl/fuel_pkg.sv
// Shared types and default constants for the BCD fuel gauge.
// Parameters are turned into BCD here so comparisons stay in the BCD domain.
package fuel_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StEmpty = 2'd2
    } fuel_state_e;

    localparam int unsigned DefDigits     = 2;
    localparam int unsigned DefFull       = 99;
    localparam int unsigned DefRefill     = 20;
    localparam int unsigned DefLowThresh  = 10;
    localparam int unsigned DefBlinkTicks = 2;

    // Up to four BCD digits, digit 0 in bits [3:0].
    function automatic logic [15:0] to_bcd(input int unsigned value);
        int unsigned rem;
        logic [15:0] bcd;
        rem = value;
        bcd = '0;
        for (int i = 0; i < 4; i++) begin
            bcd[i*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/fuel_gauge_bcd_if.sv
// Control inputs and registered status outputs of the fuel gauge.
interface fuel_gauge_bcd_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  start;
    logic                  tick;
    logic [1:0]            speed;
    logic                  add_fuel;
    logic [DIGITS*4-1:0]   fuel;
    logic                  low_fuel;
    logic                  game_over;
    logic [1:0]            state_o;

    modport master (
        output start, tick, speed, add_fuel,
        input  fuel, low_fuel, game_over, state_o
    );

    modport slave (
        input  start, tick, speed, add_fuel,
        output fuel, low_fuel, game_over, state_o
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of an add (with carry) or subtract (with borrow) chain.
// In subtract mode cin/cout carry the borrow.
module bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] y,
    output logic       cout
);
    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        y    = 4'd0;
        cout = 1'b0;
        if (sub) begin
            if (diff[4]) begin
                y    = 4'(diff + 5'd10);
                cout = 1'b1;
            end else begin
                y = diff[3:0];
            end
        end else begin
            if (sum > 5'd9) begin
                y    = 4'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                y = sum[3:0];
            end
        end
    end
endmodule

// File: rtl/fuel_gauge_bcd.sv
// BCD fuel gauge: burns fuel on prescaled ticks, refills with saturation,
// blinks a low-fuel warning and reports game over when the tank is empty.
module fuel_gauge_bcd
    import fuel_pkg::*;
#(
    parameter int unsigned DIGITS      = DefDigits,
    parameter int unsigned FULL        = DefFull,
    parameter int unsigned REFILL      = DefRefill,
    parameter int unsigned LOW_THRESH  = DefLowThresh,
    parameter int unsigned BLINK_TICKS = DefBlinkTicks
) (
    input logic            clk,
    input logic            reset,
    fuel_gauge_bcd_if.slave bus
);
    localparam int unsigned W    = DIGITS * 4;
    localparam int unsigned CntW = $clog2(BLINK_TICKS + 1);

    localparam logic [W-1:0] FullBcd   = W'(to_bcd(FULL));
    localparam logic [W-1:0] RefillBcd = W'(to_bcd(REFILL));
    localparam logic [15:0]  LowBcd    = to_bcd(LOW_THRESH);

    fuel_state_e     state_q, state_d;
    logic [W-1:0]    fuel_q, fuel_d;
    logic [1:0]      pre_q, pre_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            low_q, low_d;
    logic            go_q, go_d;

    logic [W-1:0]    arith;
    logic [DIGITS:0] carry;
    logic [W-1:0]    refilled;
    logic            do_add;
    logic            burn;
    logic            low_now, low_next;

    // One shared chain: refill adds REFILL, otherwise it decrements by one.
    assign do_add   = bus.add_fuel;
    assign carry[0] = ~do_add;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .a    (fuel_q[i*4 +: 4]),
            .b    (do_add ? RefillBcd[i*4 +: 4] : 4'd0),
            .sub  (~do_add),
            .cin  (carry[i]),
            .y    (arith[i*4 +: 4]),
            .cout (carry[i+1])
        );
    end

    // BCD ordering matches numeric ordering while every digit is 0..9.
    assign refilled = (carry[DIGITS] || (arith > FullBcd)) ? FullBcd : arith;

    always_comb begin
        state_d = state_q;
        fuel_d  = fuel_q;
        pre_d   = pre_q;
        burn    = 1'b0;
        case (state_q)
            StIdle, StEmpty: begin
                if (bus.start) begin
                    state_d = StRun;
                    fuel_d  = FullBcd;
                    pre_d   = '0;
                end
            end
            StRun: begin
                if (bus.start) begin
                    fuel_d = FullBcd;
                    pre_d  = '0;
                end else if (fuel_q == '0) begin
                    state_d = StEmpty;
                end else begin
                    if (bus.tick && (bus.speed != 2'd0)) begin
                        if (pre_q >= (2'd3 - bus.speed)) begin
                            burn  = 1'b1;
                            pre_d = '0;
                        end else begin
                            pre_d = pre_q + 2'd1;
                        end
                    end
                    // A refill wins over a coincident burn.
                    if (bus.add_fuel) begin
                        fuel_d = refilled;
                    end else if (burn) begin
                        fuel_d = arith;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign low_now  = (state_q == StRun) && (16'(fuel_q) < LowBcd);
    assign low_next = (state_d == StRun) && (16'(fuel_d) < LowBcd);
    assign go_d     = (state_d == StEmpty);

    always_comb begin
        low_d = low_q;
        cnt_d = cnt_q;
        if (!low_next) begin
            low_d = 1'b0;
            cnt_d = '0;
        end else if (!low_now) begin
            low_d = 1'b1;
            cnt_d = '0;
        end else if (bus.tick) begin
            if (cnt_q == CntW'(BLINK_TICKS - 1)) begin
                low_d = ~low_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            fuel_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            low_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fuel_q  <= fuel_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            go_q    <= go_d;
        end
    end

    assign bus.fuel      = fuel_q;
    assign bus.low_fuel  = low_q;
    assign bus.game_over = go_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_fuel_gauge_bcd.sv
// Scoreboard bench for fuel_gauge_bcd against a decimal reference model.
module tb_fuel_gauge_bcd;
    localparam int DIGITS = 2;
    localparam int FULL   = 99;
    localparam int REFILL = 20;
    localparam int LOW    = 10;
    localparam int BLINK  = 2;

    typedef struct {
        logic [7:0] fuel;
        bit         low;
        bit         go;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    int m_state = 0;
    int m_fuel = 0;
    int m_pre = 0;
    int m_ticks = 0;
    bit m_low = 1'b0;

    fuel_gauge_bcd_if #(.DIGITS(DIGITS)) bus ();

    fuel_gauge_bcd #(
        .DIGITS      (DIGITS),
        .FULL        (FULL),
        .REFILL      (REFILL),
        .LOW_THRESH  (LOW),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec2bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_fuel  = 0;
        m_pre   = 0;
        m_ticks = 0;
        m_low   = 1'b0;
    endtask

    // Decimal model: periods and saturation from plain arithmetic.
    task automatic model_step(input bit st, input bit tk, input int sp, input bit ad);
        bit was_low, is_low, burned;
        int nf, ns;
        exp_t e;
        was_low = (m_state == 1) && (m_fuel < LOW);
        nf = m_fuel;
        ns = m_state;
        burned = 1'b0;
        if (st) begin
            ns = 1;
            nf = FULL;
            m_pre = 0;
        end else if (m_state == 1) begin
            if (m_fuel == 0) begin
                ns = 2;
            end else begin
                if (tk && sp != 0) begin
                    if (m_pre + 1 >= 4 - sp) begin
                        burned = 1'b1;
                        m_pre = 0;
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
                if (ad) nf = (m_fuel + REFILL > FULL) ? FULL : m_fuel + REFILL;
                else if (burned) nf = m_fuel - 1;
            end
        end
        is_low = (ns == 1) && (nf < LOW);
        if (!is_low) begin
            m_low = 1'b0;
            m_ticks = 0;
        end else if (!was_low) begin
            m_low = 1'b1;
            m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            m_low = ((m_ticks / BLINK) % 2) == 0;
        end
        m_state = ns;
        m_fuel = nf;
        e.fuel = dec2bcd(m_fuel);
        e.low  = m_low;
        e.go   = (m_state == 2);
        e.st   = 2'(m_state);
        sb.push_back(e);
    endtask

    task automatic drive(input bit st, input bit tk, input int sp, input bit ad);
        @(negedge clk);
        bus.start    = st;
        bus.tick     = tk;
        bus.speed    = 2'(sp);
        bus.add_fuel = ad;
        model_step(st, tk, sp, ad);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic burn_to(input int target);
        for (int i = 0; i < 200 && m_fuel > target; i++) drive(1'b0, 1'b1, 3, 1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.tick = 1'b0;
        bus.add_fuel = 1'b0;
        #1;
        check("reset_fuel", int'(bus.fuel), 0);
        check("reset_state", int'(bus.state_o), 0);
        check("reset_low_go", int'({bus.low_fuel, bus.game_over}), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one expected entry per clock edge after each driven cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                bit digits_ok;
                e = sb.pop_front();
                digits_ok = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (bus.fuel[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
                end
                vectors++;
                if (bus.fuel !== e.fuel || bus.low_fuel !== e.low || bus.game_over !== e.go
                    || bus.state_o !== e.st || !digits_ok) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got fuel=%h low=%b go=%b st=%0d expected fuel=%h low=%b go=%b st=%0d digits_ok=%b",
                             $time, bus.fuel, bus.low_fuel, bus.game_over, bus.state_o,
                             e.fuel, e.low, e.go, e.st, digits_ok);
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.tick = 1'b0;
        bus.speed = 2'd0;
        bus.add_fuel = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("init_fuel", int'(bus.fuel), 0);
        check("init_state", int'(bus.state_o), 0);
        check("init_low_go", int'({bus.low_fuel, bus.game_over}), 0);
        @(negedge clk);
        reset = 1'b0;

        drive(1'b1, 1'b0, 0, 1'b0);
        settle();
        check("start_fuel", int'(bus.fuel), 'h99);
        check("start_state", int'(bus.state_o), 1);
        repeat (5) drive(1'b0, 1'b1, 3, 1'b0);
        settle();
        check("five_ticks", int'(bus.fuel), 'h94);

        burn_to(10);
        repeat (3) drive(1'b0, 1'b1, 1, 1'b0);
        settle();
        check("borrow_fuel", int'(bus.fuel), 'h09);
        check("low_rises", int'(bus.low_fuel), 1);

        drive(1'b1, 1'b0, 0, 1'b0);
        burn_to(85);
        drive(1'b0, 1'b0, 0, 1'b1);
        settle();
        check("refill_sat", int'(bus.fuel), 'h99);

        burn_to(30);
        drive(1'b0, 1'b1, 2, 1'b0);
        drive(1'b0, 1'b1, 2, 1'b1);
        settle();
        check("refill_on_burn", int'(bus.fuel), 'h50);
        drive(1'b0, 1'b1, 2, 1'b0);
        settle();
        check("pre_cleared", int'(bus.fuel), 'h50);
        drive(1'b0, 1'b1, 2, 1'b0);
        settle();
        check("burn_after_clear", int'(bus.fuel), 'h49);

        burn_to(1);
        drive(1'b0, 1'b1, 3, 1'b0);
        settle();
        check("empty_fuel", int'(bus.fuel), 0);
        check("go_not_yet", int'(bus.game_over), 0);
        drive(1'b0, 1'b0, 0, 1'b0);
        settle();
        check("go_rises", int'(bus.game_over), 1);
        drive(1'b0, 1'b0, 0, 1'b1);
        settle();
        check("empty_refill_ignored", int'(bus.fuel), 0);
        drive(1'b1, 1'b0, 0, 1'b1);
        settle();
        check("restart_fuel", int'(bus.fuel), 'h99);
        check("restart_go", int'(bus.game_over), 0);

        repeat (4) drive(1'b0, 1'b1, 3, 1'b0);
        mid_reset();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
            end else begin
                drive($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
            end
        end

        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
